// File: rtl/safe_pkg.sv
// Shared types and defaults for the safe lock controller and its code keeper.
package safe_pkg;

  localparam int SAFE_CODE_W    = 8;
  localparam int SAFE_MAX_FAILS = 3;

  typedef enum logic [2:0] {
    S_LOCKED = 3'd0,
    S_ENTER  = 3'd1,
    S_CHECK  = 3'd2,
    S_OPEN   = 3'd3,
    S_SETPW  = 3'd4
  } state_t;

  typedef enum logic [0:0] {
    K_ARMED   = 1'b0,
    K_LOCKOUT = 1'b1
  } keeper_state_t;

endpackage

// File: rtl/safe_code_keeper_lockout_timer.sv
// Lockout down-counter: load arms it, run counts it down, done flags the final cycle.
module lockout_timer #(
  parameter  int LOCKOUT_CYCLES = 16,
  localparam int CNT_W          = $clog2(LOCKOUT_CYCLES)
) (
  input  logic clk,
  input  logic RESET,
  input  logic load,
  input  logic run,
  output logic done
);

  logic [CNT_W-1:0] count_r;

  // count register: load to N-1, then step down to zero while running
  always_ff @(posedge clk) begin
    if (RESET) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= CNT_W'(LOCKOUT_CYCLES - 1);
    end else if (run && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // final lockout cycle
  always_comb begin
    done = run && (count_r == {CNT_W{1'b0}});
  end

endmodule

// File: rtl/safe_code_keeper.sv
// Password/attempt store with failed-attempt counting and timed lockout for the safe controller.
module safe_code_keeper
  import safe_pkg::*;
#(
  parameter  int CODE_W         = SAFE_CODE_W,
  parameter  int MAX_FAILS      = SAFE_MAX_FAILS,
  parameter  int LOCKOUT_CYCLES = 50_000_000,
  localparam int FAIL_W         = $clog2(MAX_FAILS + 1)
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [CODE_W-1:0] SW,
  input  logic              savePW,
  input  logic              saveAT,
  input  logic              LOCKED,
  output logic              MATCH,
  output logic              LOCKOUT,
  output logic              ALARM,
  output logic [FAIL_W-1:0] fail_count
);

  keeper_state_t     state_r, state_s;
  logic [CODE_W-1:0] pw_r, pw_s;
  logic [CODE_W-1:0] at_r, at_s;
  logic [FAIL_W-1:0] fail_r, fail_s;
  logic              saveat_q_r;
  logic              alarm_r, alarm_s;
  logic              load_s;
  logic              timer_done_s;
  logic              attempt_end_s;
  logic [CODE_W-1:0] cmp_code_s;

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .RESET(RESET),
    .load (load_s),
    .run  (state_r == K_LOCKOUT),
    .done (timer_done_s)
  );

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_r    <= K_ARMED;
      pw_r       <= {CODE_W{1'b0}};
      at_r       <= {CODE_W{1'b0}};
      fail_r     <= {FAIL_W{1'b0}};
      saveat_q_r <= 1'b0;
      alarm_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      pw_r       <= pw_s;
      at_r       <= at_s;
      fail_r     <= fail_s;
      saveat_q_r <= saveAT;
      alarm_r    <= alarm_s;
    end
  end

  // next-state: captures, attempt evaluation, lockout entry/exit
  always_comb begin
    state_s       = state_r;
    pw_s          = pw_r;
    at_s          = at_r;
    fail_s        = fail_r;
    alarm_s       = 1'b0;
    load_s        = 1'b0;
    attempt_end_s = saveat_q_r && !saveAT;

    // savePW wins when both strobes are high; attempts are frozen during lockout
    if (savePW) begin
      pw_s = SW;
    end else if (saveAT && (state_r == K_ARMED)) begin
      at_s = SW;
    end else begin
      at_s = at_r;
    end

    case (state_r)
      K_ARMED: begin
        if (!LOCKED) begin
          fail_s = {FAIL_W{1'b0}};
        end else if (attempt_end_s) begin
          if (at_r == pw_r) begin
            fail_s = {FAIL_W{1'b0}};
          end else if (fail_r >= FAIL_W'(MAX_FAILS - 1)) begin
            fail_s  = FAIL_W'(MAX_FAILS);
            state_s = K_LOCKOUT;
            load_s  = 1'b1;
            alarm_s = 1'b1;
          end else begin
            fail_s = fail_r + FAIL_W'(1);
          end
        end else begin
          fail_s = fail_r;
        end
      end
      K_LOCKOUT: begin
        if (timer_done_s) begin
          state_s = K_ARMED;
          fail_s  = {FAIL_W{1'b0}};
        end else begin
          state_s = K_LOCKOUT;
        end
      end
      default: begin
        state_s = K_ARMED;
        fail_s  = {FAIL_W{1'b0}};
      end
    endcase
  end

  // MATCH is combinational so the controller sees it while still sampling the attempt
  always_comb begin
    cmp_code_s = saveAT ? SW : at_r;
    MATCH      = (cmp_code_s == pw_r) && (state_r == K_ARMED);
    LOCKOUT    = (state_r == K_LOCKOUT);
    ALARM      = alarm_r;
    fail_count = fail_r;
  end

endmodule

// File: tb/tb_safe_code_keeper.sv
// Self-checking bench for safe_code_keeper: directed table, corner sequences, random vs reference model.
module tb_safe_code_keeper;

  localparam int CW = 8;
  localparam int MF = 3;
  localparam int LC = 16;
  localparam int FW = $clog2(MF + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] sw;
  logic          spw, sat, lk;
  logic          match, lockout, alarm;
  logic [FW-1:0] fail_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit            m_valid = 1'b0;
  logic [CW-1:0] m_pw = '0, m_at = '0;
  int            m_fails = 0;
  int            m_left = 0;
  bit            m_alarm = 1'b0;
  bit            m_prev = 1'b0;

  always #5 clk = ~clk;

  safe_code_keeper #(
    .CODE_W(CW), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .RESET(rst), .SW(sw), .savePW(spw), .saveAT(sat), .LOCKED(lk),
    .MATCH(match), .LOCKOUT(lockout), .ALARM(alarm), .fail_count(fail_count)
  );

  typedef struct {
    bit       r;
    bit [7:0] s;
    bit       p;
    bit       a;
    bit       l;
    bit       chk;
    bit       e_match;
    bit       e_lock;
    bit       e_alarm;
    int       e_fail;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input logic [CW-1:0] s, input bit p, input bit a, input bit l);
    rst = r; sw = s; spw = p; sat = a; lk = l;
    #1;
    if (m_valid) begin
      chk("model_match", int'(match),
          int'((((sat ? sw : m_at) == m_pw) && (m_left == 0))));
      chk("model_lockout", int'(lockout), int'(m_left > 0));
      chk("model_alarm", int'(alarm), int'(m_alarm));
      chk("model_fail", int'(fail_count), m_fails);
    end
  endtask

  // apply one clock edge to the model using the inputs currently driven
  task automatic adv();
    bit end_s, armed;
    @(posedge clk);
    end_s = m_prev && !sat;
    armed = (m_left == 0);
    if (rst) begin
      m_valid = 1'b1; m_pw = '0; m_at = '0; m_fails = 0; m_left = 0; m_alarm = 1'b0;
    end else begin
      m_alarm = 1'b0;
      if (armed) begin
        if (!lk) m_fails = 0;
        else if (end_s) begin
          if (m_at == m_pw) m_fails = 0;
          else begin
            m_fails++;
            if (m_fails == MF) begin
              m_left  = LC;
              m_alarm = 1'b1;
            end
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) m_fails = 0;
      end
      if (spw) m_pw = sw;
      else if (sat && armed) m_at = sw;
    end
    m_prev = rst ? 1'b0 : sat;
    @(negedge clk);
  endtask

  task automatic step(input bit r, input logic [CW-1:0] s, input bit p, input bit a, input bit l);
    drive(r, s, p, a, l);
    adv();
  endtask

  task automatic attempt(input logic [CW-1:0] s);
    step(1'b0, s, 1'b0, 1'b1, 1'b1);
    step(1'b0, s, 1'b0, 1'b1, 1'b1);
    step(1'b0, s, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int lock_cycles;
    rst = 1'b1; sw = '0; spw = 1'b0; sat = 1'b0; lk = 1'b1;

    //          r  sw     p  a  l  chk  mat lck alm fail
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[11] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[14] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].a, vecs[i].l);
      if (vecs[i].chk) begin
        chk($sformatf("tbl%0d_match", i), int'(match), int'(vecs[i].e_match));
        chk($sformatf("tbl%0d_lockout", i), int'(lockout), int'(vecs[i].e_lock));
        chk($sformatf("tbl%0d_alarm", i), int'(alarm), int'(vecs[i].e_alarm));
        chk($sformatf("tbl%0d_fail", i), int'(fail_count), vecs[i].e_fail);
      end
      adv();
    end

    // attempt during lockout is ignored, then measure the full window
    lock_cycles = 2;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
      chk("lk_match", int'(match), 0);
      chk("lk_fail", int'(fail_count), 3);
      if (lockout) lock_cycles++;
      adv();
    end
    for (int g = 0; g < 40; g++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      if (!lockout) break;
      chk("lk_fail_hold", int'(fail_count), 3);
      lock_cycles++;
      adv();
    end
    chk("lock_len", lock_cycles, LC);
    chk("post_lock_fail", int'(fail_count), 0);
    chk("post_lock_at_kept", int'(match), 0);
    adv();
    drive(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
    chk("post_lock_match", int'(match), 1);
    adv();
    step(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);

    // open safe clears the fail history
    attempt(8'h3C);
    attempt(8'h3C);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("two_fails", int'(fail_count), 2);
    adv();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("open_clear", int'(fail_count), 0);
    adv();
    attempt(8'h3C);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("after_open_fail", int'(fail_count), 1);
    chk("after_open_nolock", int'(lockout), 0);
    adv();

    // reset in the middle of a lockout, then both strobes together
    attempt(8'h3C);
    attempt(8'h3C);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_lockout", int'(lockout), 1);
    adv();
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_lockout", int'(lockout), 0);
    chk("rst_fail", int'(fail_count), 0);
    chk("rst_pw_zero", int'(match), 1);
    adv();
    step(1'b0, 8'h11, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("both_at_held", int'(match), 0);
    adv();
    drive(1'b0, 8'h11, 1'b0, 1'b1, 1'b1);
    chk("both_pw_taken", int'(match), 1);
    adv();

    // randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      logic [CW-1:0] s;
      bit a;
      case ($urandom_range(0, 2))
        0:       s = 8'hA5;
        1:       s = 8'h3C;
        default: s = CW'($urandom);
      endcase
      a = ($urandom_range(0, 3) == 0) ? !sat : sat;
      step(($urandom_range(0, 399) == 0), s, ($urandom_range(0, 15) == 0), a,
           ($urandom_range(0, 19) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/safe_code_keeper.md
Name: safe_code_keeper

Overview:
- Datapath/responder partner of the safe lock controller FSM.
- Consumes the controller's savePW / saveAT / LOCKED strobes, holds the stored password and the entered attempt, and returns MATCH.
- Adds brute-force protection: counts consecutive failed attempts and enforces a timed lockout window, during which MATCH is forced low.
- Sits between the switch/keypad inputs and the controller FSM in the safe top level.

Parameters:
- CODE_W, 8, width of password/attempt code in bits.
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYCLES, 50_000_000, lockout duration in clk cycles (>=2).
- FAIL_W, $clog2(MAX_FAILS+1), width of fail_count (derived localparam).

Ports:
- clk  input  1  system clock, all state on rising edge.
- RESET  input  1  synchronous reset, active-high; one clock, synchronous active-high reset.
- SW  input  CODE_W  code value presented by user switches.
- savePW  input  1  controller strobe: capture password (level, may last many cycles).
- saveAT  input  1  controller strobe: capture attempt (level, may last many cycles).
- LOCKED  input  1  controller lock status.
- MATCH  output  1  attempt equals stored password and not in lockout.
- LOCKOUT  output  1  lockout window active.
- ALARM  output  1  one-cycle pulse on the cycle lockout begins.
- fail_count  output  FAIL_W  consecutive failed attempts since last success/open.

Behaviour:
- Reset (RESET=1 at posedge): pw_reg=0, at_reg=0, fail_count=0, lockout counter=0, state=ARMED, edge-detect regs=0. Outputs LOCKOUT=0, ALARM=0, MATCH=1 (0==0), fail_count=0.
- Reset mid-lockout aborts the lockout immediately.
- Password capture: every cycle savePW=1, pw_reg<=SW; last value wins. Allowed during lockout.
- Attempt capture: every cycle saveAT=1 and savePW=0 and state=ARMED, at_reg<=SW. If both strobes are high (illegal), savePW wins and at_reg holds.
- MATCH is combinational, so the controller sees a valid MATCH in the same cycle it samples ENTER low:
  - cmp = (saveAT ? SW : at_reg) == pw_reg.
  - MATCH = cmp && (state==ARMED).
- Attempt end = saveAT falling edge (saveAT_q=1, saveAT=0). Evaluate using at_reg and pw_reg:
  - ARMED, match: fail_count<=0.
  - ARMED, mismatch, fail_count<MAX_FAILS-1: fail_count<=fail_count+1.
  - ARMED, mismatch, fail_count==MAX_FAILS-1: fail_count<=MAX_FAILS, state<=LOCKOUT, lockout counter<=LOCKOUT_CYCLES-1, ALARM=1 next cycle for exactly one cycle.
  - LOCKOUT: attempt end ignored; fail_count unchanged.
- State LOCKOUT:
  - LOCKOUT=1; counter decrements each cycle.
  - When the counter is 0: state<=ARMED, fail_count<=0, LOCKOUT deasserts the following cycle.
  - Duration: exactly LOCKOUT_CYCLES cycles with LOCKOUT=1.
- LOCKED=0 (safe open) while ARMED: fail_count<=0 every cycle. LOCKED has no effect on LOCKOUT state.
- fail_count saturates at MAX_FAILS; it never wraps.
- No internal combinational loops; MATCH depends only on SW, saveAT, registers.

Decomposition:
- Package safe_pkg: the controller state_t enum (shared with the FSM), keeper_state_t {ARMED, LOCKOUT}, default CODE_W and MAX_FAILS constants.
- One natural sub-module: lockout_timer (load, count-down, done pulse; parameter LOCKOUT_CYCLES).
- Edge detection and compare stay inline.

Test Plan (bench uses LOCKOUT_CYCLES=16, MAX_FAILS=3, CODE_W=8):
1. RESET 2 cycles -> LOCKOUT=0, ALARM=0, fail_count=0, MATCH=1. Then savePW=1 with SW=8'hA5 for 3 cycles -> pw_reg=A5.
2. saveAT=1 with SW=8'hA5 for 2 cycles -> MATCH=1 same cycle. Release saveAT -> fail_count=0.
3. Three attempts with SW=8'h3C, each ending on a saveAT fall -> fail_count 1, 2, 3. ALARM single pulse after the third. LOCKOUT=1 for exactly 16 cycles, then fail_count=0.
4. During lockout, saveAT=1 with SW=8'hA5 -> MATCH=0, at_reg unchanged, fail_count stays 3. After lockout the same attempt -> MATCH=1.
5. Two failures (fail_count=2), then LOCKED=0 one cycle -> fail_count=0. A third failure -> fail_count=1, no lockout.
6. Mid-lockout RESET -> next cycle LOCKOUT=0, fail_count=0, pw_reg=0. Also savePW=saveAT=1 with SW=8'h11 -> pw_reg=11, at_reg unchanged.
